// File: rtl/ahead_adder_pkg.sv
// Shared width and nibble type for the 4-bit carry-lookahead adder.
package ahead_adder_pkg;
    localparam int CLA_W = 4;
    typedef logic [CLA_W-1:0] cla_nib_t;
endpackage

// File: rtl/ahead_adder_cla4_cell.sv
// Combinational 4-bit carry-lookahead cell.
// All carries are flat two-level sum-of-products of the per-bit G/P terms.
module cla4_cell
    import ahead_adder_pkg::*;
(
    input  logic     a_in_unused_guard,
    input  cla_nib_t a,
    input  cla_nib_t b,
    input  logic     c0,
    output cla_nib_t f,
    output logic     c4,
    output logic     pg,
    output logic     gg
);
    cla_nib_t   g;
    cla_nib_t   p;
    logic [4:0] c;

    for (genvar i = 0; i < CLA_W; i++) begin : g_bit
        assign g[i] = a[i] & b[i];
        assign p[i] = a[i] ^ b[i];
        assign f[i] = p[i] ^ c[i];
    end

    // No carry is derived from another carry: each level sees only G, P and c0.
    assign c[0] = c0;
    assign c[1] = g[0] | (p[0] & c0);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c0);

    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign pg = &p;
    assign c4 = c[4];

    logic unused;
    assign unused = a_in_unused_guard;
endmodule

// File: rtl/ahead_adder.sv
// Registered 4-bit carry-lookahead adder with group P/G outputs for cascading.
// One register stage behind the combinational cell; synchronous active-high reset.
module ahead_adder
    import ahead_adder_pkg::*;
#(
    parameter int WIDTH = CLA_W
) (
    input  logic     AA_CLK,
    input  logic     AA_RST,
    input  cla_nib_t AA_A,
    input  cla_nib_t AA_B,
    input  logic     AA_C_0,
    output cla_nib_t AA_F,
    output logic     AA_C_4,
    output logic     AA_PG,
    output logic     AA_GG
);
    if (WIDTH != CLA_W) begin : g_bad_width
        $error("ahead_adder: WIDTH must be 4");
    end

    cla_nib_t f;
    logic     c4;
    logic     pg;
    logic     gg;

    cla4_cell u_cell (
        .a_in_unused_guard (1'b0),
        .a                 (AA_A),
        .b                 (AA_B),
        .c0                (AA_C_0),
        .f                 (f),
        .c4                (c4),
        .pg                (pg),
        .gg                (gg)
    );

    always_ff @(posedge AA_CLK) begin
        if (AA_RST) begin
            AA_F   <= '0;
            AA_C_4 <= 1'b0;
            AA_PG  <= 1'b0;
            AA_GG  <= 1'b0;
        end else begin
            AA_F   <= f;
            AA_C_4 <= c4;
            AA_PG  <= pg;
            AA_GG  <= gg;
        end
    end
endmodule

// File: tb/tb_ahead_adder.sv
// Self-checking bench for ahead_adder against an arithmetic reference model.
module tb_ahead_adder;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a, b;
    logic       c0;
    logic [3:0] f;
    logic       c4, pg, gg;

    int checks = 0;
    int errors = 0;

    ahead_adder dut (
        .AA_CLK (clk),
        .AA_RST (rst),
        .AA_A   (a),
        .AA_B   (b),
        .AA_C_0 (c0),
        .AA_F   (f),
        .AA_C_4 (c4),
        .AA_PG  (pg),
        .AA_GG  (gg)
    );

    always #5 clk = ~clk;

    // Packed as {C_4, F[3:0], PG, GG}.
    function automatic logic [6:0] model(input logic [3:0] ma, input logic [3:0] mb, input logic mc);
        int unsigned s;
        int unsigned s0;
        logic        mpg;
        logic        mgg;
        s   = int'(ma) + int'(mb) + int'(mc);
        s0  = int'(ma) + int'(mb);
        mpg = ((ma ^ mb) == 4'hF);
        mgg = (s0 > 15);
        return {s[4:0], mpg, mgg};
    endfunction

    task automatic check(input string tag, input logic [6:0] exp);
        logic [6:0] got;
        got = {c4, f, pg, gg};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed {c4,f,pg,gg}=%b expected %b", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] da, input logic [3:0] db, input logic dc);
        a  = da;
        b  = db;
        c0 = dc;
    endtask

    // Apply inputs at a falling edge, check the registered result at the next falling edge.
    task automatic step(input string tag, input logic [3:0] da, input logic [3:0] db, input logic dc);
        @(negedge clk);
        drive(da, db, dc);
        @(negedge clk);
        check(tag, model(da, db, dc));
    endtask

    initial begin
        logic [3:0] pa, pb;
        logic       pc;
        logic [8:0] idx;

        rst = 1'b1;
        drive(4'd9, 4'd9, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("reset_cycle1", 7'b0);
        @(negedge clk);
        check("reset_cycle2", 7'b0);
        rst = 1'b0;

        step("zero",        4'd0,  4'd0,  1'b0);
        step("add_2_1_0",   4'd2,  4'd1,  1'b0);
        step("add_3_4_1",   4'd3,  4'd4,  1'b1);
        step("add_2_7_0",   4'd2,  4'd7,  1'b0);
        step("prop_15_0_1", 4'd15, 4'd0,  1'b1);
        step("gen_15_15_1", 4'd15, 4'd15, 1'b1);

        // Exhaustive back-to-back sweep: every cycle checks the previous cycle's operands.
        @(negedge clk);
        idx = '0;
        drive(idx[3:0], idx[7:4], idx[8]);
        {pc, pb, pa} = idx;
        for (int i = 1; i <= 512; i++) begin
            @(negedge clk);
            check("sweep", model(pa, pb, pc));
            if (i < 512) begin
                idx = 9'(i);
                drive(idx[3:0], idx[7:4], idx[8]);
                {pc, pb, pa} = idx;
            end
        end

        // Random back-to-back stream.
        pa = 4'($urandom); pb = 4'($urandom); pc = 1'($urandom);
        drive(pa, pb, pc);
        for (int i = 0; i < 200; i++) begin
            logic [3:0] na, nb;
            logic       nc;
            @(negedge clk);
            check("random", model(pa, pb, pc));
            na = 4'($urandom); nb = 4'($urandom); nc = 1'($urandom);
            drive(na, nb, nc);
            pa = na; pb = nb; pc = nc;
        end

        // One-cycle reset in the middle of the stream overrides the pending add.
        @(negedge clk);
        check("pre_midreset", model(pa, pb, pc));
        rst = 1'b1;
        drive(4'd15, 4'd15, 1'b1);
        @(negedge clk);
        check("midreset_zero", 7'b0);
        rst = 1'b0;
        drive(4'd6, 4'd11, 1'b1);
        @(negedge clk);
        check("post_midreset", model(4'd6, 4'd11, 1'b1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
